// File: rtl/dma_rd_mac_sched.sv
// ---------------------------------------------------------------------------
// dma_rd_mac_sched : round-robin scheduler offering MAC read queues to DMA
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dma_rd_mac_sched #(
  parameter int BURST = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cnet_reprog,
  input  logic [15:0] q_pkt_avail,
  input  logic [15:0] q_enable,
  input  logic        dma_rd_request,
  input  logic        dma_in_progress,
  input  logic        ctrl_done,
  input  logic        dma_fatal_err,
  output logic        dma_rd_request_q_vld,
  output logic [3:0]  dma_rd_request_q,
  output logic [1:0]  sched_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] BURST_INIT = 4'(BURST);

  state_t      state, state_nxt;
  logic [3:0]  rr_ptr, rr_ptr_nxt;
  logic [3:0]  credit, credit_nxt;
  logic [3:0]  q_nxt;
  logic        vld_nxt;
  logic [15:0] eligible;
  logic [3:0]  sel;
  logic [3:0]  idx;
  logic        sel_found;

  assign eligible    = q_pkt_avail & q_enable;
  assign sched_state = state;

  // First eligible queue at or above rr_ptr, wrapping through 15 -> 0.
  always_comb begin
    sel       = 4'd0;
    sel_found = 1'b0;
    idx       = rr_ptr;
    for (int i = 0; i < 16; i++) begin
      idx = rr_ptr + 4'(i);
      if (!sel_found && eligible[idx]) begin
        sel       = idx;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    q_nxt      = dma_rd_request_q;
    vld_nxt    = 1'b0;
    rr_ptr_nxt = rr_ptr;
    credit_nxt = credit;
    case (state)
      IDLE: begin
        if (sel_found) begin
          q_nxt     = sel;
          vld_nxt   = 1'b1;
          state_nxt = OFFER;
          // Burst credit belongs to one queue; a new queue starts fresh.
          if (sel != dma_rd_request_q) credit_nxt = BURST_INIT;
        end
      end
      OFFER: begin
        if (dma_rd_request) begin
          state_nxt = XFER;
        end else if (!eligible[dma_rd_request_q] && !dma_in_progress) begin
          state_nxt = IDLE;
        end else begin
          vld_nxt = 1'b1;
        end
      end
      XFER: begin
        if (ctrl_done && !dma_fatal_err) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (credit > 4'd1) begin
          credit_nxt = credit - 4'd1;
          rr_ptr_nxt = dma_rd_request_q;
        end else begin
          credit_nxt = BURST_INIT;
          rr_ptr_nxt = dma_rd_request_q + 4'd1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      dma_rd_request_q_vld <= 1'b0;
      dma_rd_request_q     <= 4'd0;
      rr_ptr               <= 4'd0;
      credit               <= BURST_INIT;
    end else if (cnet_reprog) begin
      state                <= IDLE;
      dma_rd_request_q_vld <= 1'b0;
      dma_rd_request_q     <= 4'd0;
      rr_ptr               <= 4'd0;
      credit               <= BURST_INIT;
    end else begin
      state                <= state_nxt;
      dma_rd_request_q_vld <= vld_nxt;
      dma_rd_request_q     <= q_nxt;
      rr_ptr               <= rr_ptr_nxt;
      credit               <= credit_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dma_rd_mac_sched.sv
// ---------------------------------------------------------------------------
// tb_dma_rd_mac_sched : bench for dma_rd_mac_sched (BURST=1 and BURST=3 side by side)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dma_rd_mac_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cnet_reprog;
  logic [15:0] avail1, avail3, enable;
  logic        req, inprog, done, fatal;
  logic        vld1, vld3;
  logic [3:0]  q1, q3;
  logic [1:0]  st1, st3;

  always #5 clk = ~clk;

  dma_rd_mac_sched #(.BURST(1)) u_b1 (
    .clk(clk), .reset_n(reset_n), .cnet_reprog(cnet_reprog),
    .q_pkt_avail(avail1), .q_enable(enable),
    .dma_rd_request(req), .dma_in_progress(inprog),
    .ctrl_done(done), .dma_fatal_err(fatal),
    .dma_rd_request_q_vld(vld1), .dma_rd_request_q(q1), .sched_state(st1)
  );

  dma_rd_mac_sched #(.BURST(3)) u_b3 (
    .clk(clk), .reset_n(reset_n), .cnet_reprog(cnet_reprog),
    .q_pkt_avail(avail3), .q_enable(enable),
    .dma_rd_request(req), .dma_in_progress(inprog),
    .ctrl_done(done), .dma_fatal_err(fatal),
    .dma_rd_request_q_vld(vld3), .dma_rd_request_q(q3), .sched_state(st3)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: index 0 tracks BURST=1, index 1 tracks BURST=3.
  int m_state[2];
  int m_q[2];
  int m_rr[2];
  int m_credit[2];

  typedef struct {
    logic [15:0] avail;
    logic        req;
    logic        inprog;
    logic        done;
    logic        fatal;
    logic        reprog;
    logic        vld;
    logic [3:0]  q;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl[14];

  function automatic int burst_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int first_elig(logic [15:0] e, int rr);
    for (int i = 0; i < 16; i++)
      if (e[(rr + i) % 16]) return (rr + i) % 16;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k]  = 0;
      m_q[k]      = 0;
      m_rr[k]     = 0;
      m_credit[k] = burst_of(k);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [15:0] e;
      int          g;
      e = ((k == 0) ? avail1 : avail3) & enable;
      if (cnet_reprog) begin
        m_state[k]  = 0;
        m_q[k]      = 0;
        m_rr[k]     = 0;
        m_credit[k] = burst_of(k);
      end else begin
        case (m_state[k])
          0: begin
            g = first_elig(e, m_rr[k]);
            if (g >= 0) begin
              if (g != m_q[k]) m_credit[k] = burst_of(k);
              m_q[k]     = g;
              m_state[k] = 1;
            end
          end
          1: begin
            if (req) m_state[k] = 2;
            else if (!e[m_q[k]] && !inprog) m_state[k] = 0;
          end
          2: begin
            if (done && !fatal) m_state[k] = 3;
          end
          default: begin
            if (m_credit[k] > 1) begin
              m_credit[k] = m_credit[k] - 1;
              m_rr[k]     = m_q[k];
            end else begin
              m_credit[k] = burst_of(k);
              m_rr[k]     = (m_q[k] + 1) % 16;
            end
            m_state[k] = 0;
          end
        endcase
      end
    end
  endtask

  task automatic check(string nm, int k, logic ev, int eq, int es);
    logic av;
    int   aq, as;
    av = (k == 0) ? vld1 : vld3;
    aq = (k == 0) ? int'(q1) : int'(q3);
    as = (k == 0) ? int'(st1) : int'(st3);
    checks++;
    if (av !== ev || aq != eq || as != es) begin
      failures++;
      $display("FAIL %s burst%0d: got vld=%0b q=%0d st=%0d, expected vld=%0b q=%0d st=%0d",
               nm, burst_of(k), av, aq, as, ev, eq, es);
    end
  endtask

  task automatic check_model(string nm);
    for (int k = 0; k < 2; k++)
      check(nm, k, (m_state[k] == 1), m_q[k], m_state[k]);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Accept the current offer and complete the transfer, then expect the next offer.
  task automatic grant(string nm, int e1, int e3);
    check(nm, 0, 1'b1, e1, 1);
    check(nm, 1, 1'b1, e3, 1);
    req = 1'b1; inprog = 1'b1; step();
    req = 1'b0; step();
    step();
    done = 1'b1; step();
    done = 1'b0; inprog = 1'b0; step();
    step();
    check_model({nm, "_model"});
  endtask

  initial begin
    int exp1a[7] = '{0, 7, 0, 7, 0, 7, 0};
    int exp3a[7] = '{0, 0, 0, 15, 15, 15, 0};
    int exp1b[5] = '{4, 5, 6, 7, 4};
    int exp3b[5] = '{4, 4, 4, 5, 5};

    tbl[0]  = '{16'h0010, 0, 0, 0, 0, 0, 1, 4'd4, 2'd1};
    tbl[1]  = '{16'h0010, 0, 0, 0, 0, 0, 1, 4'd4, 2'd1};
    tbl[2]  = '{16'h0000, 0, 0, 0, 0, 0, 0, 4'd4, 2'd0};
    tbl[3]  = '{16'h0000, 0, 0, 0, 0, 0, 0, 4'd4, 2'd0};
    tbl[4]  = '{16'h0010, 0, 0, 0, 0, 0, 1, 4'd4, 2'd1};
    tbl[5]  = '{16'h0000, 0, 1, 0, 0, 0, 1, 4'd4, 2'd1};
    tbl[6]  = '{16'h0000, 1, 0, 0, 0, 0, 0, 4'd4, 2'd2};
    tbl[7]  = '{16'h0000, 0, 1, 0, 0, 0, 0, 4'd4, 2'd2};
    tbl[8]  = '{16'h0000, 0, 1, 1, 1, 0, 0, 4'd4, 2'd2};
    tbl[9]  = '{16'h0000, 0, 1, 1, 1, 0, 0, 4'd4, 2'd2};
    tbl[10] = '{16'h0000, 0, 0, 0, 0, 1, 0, 4'd0, 2'd0};
    tbl[11] = '{16'h0000, 0, 0, 0, 0, 0, 0, 4'd0, 2'd0};
    tbl[12] = '{16'h0000, 1, 0, 0, 0, 0, 0, 4'd0, 2'd0};
    tbl[13] = '{16'h0000, 0, 0, 1, 0, 0, 0, 4'd0, 2'd0};

    reset_n = 1'b0; cnet_reprog = 1'b0;
    avail1 = 16'h0; avail3 = 16'h0; enable = 16'hFFFF;
    req = 1'b0; inprog = 1'b0; done = 1'b0; fatal = 1'b0;
    model_reset();
    avail1 = 16'hFFFF; avail3 = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, 1'b0, 0, 0);
    check("reset", 1, 1'b0, 0, 0);
    avail1 = 16'h0; avail3 = 16'h0;
    reset_n = 1'b1;

    // Offer/withdraw/hold, request-wins, fatal hold, reprog and stray pulses.
    for (int i = 0; i < 14; i++) begin
      avail1 = tbl[i].avail; avail3 = tbl[i].avail;
      req = tbl[i].req; inprog = tbl[i].inprog; done = tbl[i].done;
      fatal = tbl[i].fatal; cnet_reprog = tbl[i].reprog;
      step();
      for (int k = 0; k < 2; k++)
        check($sformatf("vec%0d", i), k, tbl[i].vld, int'(tbl[i].q), int'(tbl[i].st));
    end
    req = 1'b0; done = 1'b0; fatal = 1'b0; inprog = 1'b0; cnet_reprog = 1'b0;

    // Async reset while offering, observed before any clock edge.
    avail1 = 16'h0010; avail3 = 16'h0010;
    step();
    check("pre_async_reset", 0, 1'b1, 4, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 0, 1'b0, 0, 0);
    check("async_reset", 1, 1'b0, 0, 0);
    model_reset();
    avail1 = 16'h0; avail3 = 16'h0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Round-robin with burst credit and 15 -> 0 wrap.
    avail1 = 16'h0081; avail3 = 16'h8001;
    step();
    check("first_offer_latency", 0, 1'b1, 0, 1);
    check("first_offer_latency", 1, 1'b1, 0, 1);
    for (int g = 0; g < 7; g++)
      grant($sformatf("rr_grant%0d", g), exp1a[g], exp3a[g]);

    // Enable mask restricts grants to queues 4..7.
    avail1 = 16'h0; avail3 = 16'h0;
    cnet_reprog = 1'b1; step(); cnet_reprog = 1'b0;
    enable = 16'h00F0; avail1 = 16'hFFFF; avail3 = 16'hFFFF;
    step();
    for (int g = 0; g < 5; g++)
      grant($sformatf("mask_grant%0d", g), exp1b[g], exp3b[g]);

    // Randomized traffic against the reference model.
    cnet_reprog = 1'b1; step(); cnet_reprog = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      avail1 = a; avail3 = a;
      enable = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
      req         = ($urandom_range(0, 9) < 3);
      inprog      = ($urandom_range(0, 9) < 4);
      done        = ($urandom_range(0, 9) < 3);
      fatal       = ($urandom_range(0, 49) == 0);
      cnet_reprog = ($urandom_range(0, 99) == 0);
      step();
      check_model($sformatf("rand%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dma_rd_mac_sched.md
DMA_RD_MAC_SCHED -- requirements
Module: dma_rd_mac_sched

Interface
REQ-001 Parameter BURST, default 1: packets one queue may take back-to-back before the pointer advances; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cnet_reprog  input  1  CNET being reprogrammed; synchronous clear, same effect as reset.
REQ-005 q_pkt_avail  input  16  per-MAC "packet waiting for DMA read" flags.
REQ-006 q_enable  input  16  per-MAC software enable mask.
REQ-007 dma_rd_request  input  1  one-cycle pulse from DMA control: offered queue accepted.
REQ-008 dma_in_progress  input  1  DMA control not idle.
REQ-009 ctrl_done  input  1  DMA control in its done state (one cycle per transfer).
REQ-010 dma_fatal_err  input  1  DMA control in its error state.
REQ-011 dma_rd_request_q_vld  output  1  a read queue is offered.
REQ-012 dma_rd_request_q  output  4  index of offered/active queue.
REQ-013 sched_state  output  2  state encoding, debug only.

Function
REQ-014 Eligible vector = q_pkt_avail & q_enable, evaluated combinationally each cycle.
REQ-015 States: IDLE=0, OFFER=1, XFER=2, RELEASE=3; all outputs registered.
REQ-016 IDLE: if eligible nonzero, select the first eligible index at or above rr_ptr, wrapping 15->0; load dma_rd_request_q; assert vld; go OFFER next cycle (1-cycle latency from eligibility to vld).
REQ-017 IDLE with eligible zero: stay IDLE, vld=0, dma_rd_request_q holds last value.
REQ-018 OFFER: vld=1 and dma_rd_request_q stable every cycle.
REQ-019 OFFER and dma_rd_request=1: vld=0 next cycle, go XFER.
REQ-020 OFFER, offered queue no longer eligible, dma_in_progress=0: withdraw (vld=0), go IDLE; rr_ptr and credit unchanged.
REQ-021 OFFER with dma_in_progress=1: never withdraw, regardless of eligibility.
REQ-022 dma_rd_request_q never changes in OFFER or XFER.
REQ-023 XFER: vld=0; ctrl_done=1 -> RELEASE.
REQ-024 XFER with dma_fatal_err=1: stay in XFER until reset or cnet_reprog.
REQ-025 RELEASE (one cycle): if credit>1 -> credit decrements, rr_ptr=dma_rd_request_q.
REQ-026 RELEASE otherwise: credit=BURST, rr_ptr=(dma_rd_request_q+1) mod 16.
REQ-027 RELEASE always -> IDLE.
REQ-028 Credit applies only while the same queue stays eligible; if IDLE selects a different queue, credit reloads to BURST on selection.
REQ-029 dma_rd_request pulse outside OFFER: ignored.
REQ-030 ctrl_done outside XFER: ignored.
REQ-031 dma_rd_request and loss of eligibility in the same OFFER cycle: request wins, go XFER.
REQ-032 rr_ptr is 4 bits and wraps naturally; credit is 4 bits.

Reset
REQ-033 reset_n low (async) or cnet_reprog high (next edge): state=IDLE, vld=0, dma_rd_request_q=0, rr_ptr=0, credit=BURST, sched_state=0.
REQ-034 Reset or cnet_reprog during OFFER/XFER: abandon the transfer, no credit/pointer update.

Verification
REQ-035 BURST=1, enable=FFFF, avail=0x0081, ack each offer, ctrl_done 3 cycles later -> grants 0,7,0,7; vld one cycle after avail.
REQ-036 BURST=3, avail=0x8001 held -> grants 0,0,0,15,15,15,0; pointer wraps 15->0.
REQ-037 Offer q=4, drop avail[4] with dma_in_progress=0 -> vld falls next cycle, IDLE, q stays 4; with dma_in_progress=1 -> vld held.
REQ-038 In XFER, dma_fatal_err=1, ctrl_done pulsed -> stays XFER, vld=0; cnet_reprog pulse -> IDLE, q=0.
REQ-039 reset_n low mid-OFFER with no clock edge -> vld=0, sched_state=0 immediately.
REQ-040 enable=0x00F0, avail=FFFF -> only queues 4..7 granted, in order 4,5,6,7,4.
